// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared sizing defaults and ingress FSM encoding for the UART receive FIFO
package uart_rx_fifo_pkg;
    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF = $clog2(DEPTH_DEF);
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} ingress_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: byte storage with one synchronous write port and one asynchronous read port
module fifo_mem import uart_rx_fifo_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from the serial receiver into a first-word fall-through FIFO
module uart_rx_fifo import uart_rx_fifo_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    inData,
    input  logic          inRdy,
    output logic          inDone,
    input  logic          rd,
    output logic [7:0]    data,
    output logic          rdy,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          clrOvf
);
    ingress_t state, state_n;
    logic [AW-1:0] wptr, rptr;
    logic [7:0] head;
    logic take, full, push, pop, drop;
    always_comb begin
        take = !rst && state == IDLE && inRdy;
        full = count == (AW+1)'(DEPTH);
        pop = !rst && rd && count != '0;
        push = take && (!full || pop);
        drop = take && !push;
        state_n = (state == IDLE && inRdy) ? ACK : IDLE;
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            ovf <= 1'b0;
        end else begin
            wptr <= wptr + AW'(push);
            rptr <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            ovf <= drop | (ovf & ~clrOvf);
        end
    end
    // Acknowledge is the registered ACK state, so the receiver sees it the cycle after capture
    assign inDone = state == ACK;
    assign rdy = !rst && count != '0;
    assign data = rdy ? head : 8'h00;
    fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(clk),
        .we(push),
        .waddr(wptr),
        .wdata(inData),
        .raddr(rptr),
        .rdata(head)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for the UART receive FIFO
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic rst, inRdy, inDone, rd, rdy, ovf, clrOvf;
    logic [7:0] inData, data;
    logic [AW:0] count;
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .inData(inData), .inRdy(inRdy), .inDone(inDone),
        .rd(rd), .data(data), .rdy(rdy), .count(count), .ovf(ovf), .clrOvf(clrOvf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read pops the scoreboard and compares the head byte
    always @(negedge clk) begin
        if (rd && rdy && !rst) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 32'(data), 32'hFFFF_FFFF);
            else chk("pop_data", 32'(data), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        inData = b;
        inRdy = 1'b1;
        while (!inDone && n < 10) begin
            step();
            n++;
        end
        if (!inDone) chk("inDone_timeout", 0, 1);
        step();
        inRdy = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 8'(i));
            send(base + 8'(i));
        end
    endtask

    task automatic drain(input int n);
        rd = 1'b1;
        step(n);
        rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inRdy = 1'b0; inData = 8'h00; rd = 1'b0; clrOvf = 1'b0;
        step(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_inDone", 32'(inDone), 0);
        rst = 1'b0;
        step();
        // Basic single byte
        inData = 8'h41; inRdy = 1'b1;
        exp_q.push_back(8'h41);
        step();
        chk("basic_inDone", 32'(inDone), 1);
        chk("basic_rdy", 32'(rdy), 1);
        chk("basic_data", 32'(data), 32'h41);
        chk("basic_count", 32'(count), 1);
        step();
        inRdy = 1'b0;
        chk("basic_single_pulse", 32'(inDone), 0);
        step();
        chk("basic_no_second", 32'(inDone), 0);
        drain(1);
        chk("basic_empty_rdy", 32'(rdy), 0);
        chk("basic_empty_data", 32'(data), 0);
        chk("basic_empty_count", 32'(count), 0);
        // Read while empty has no effect
        drain(1);
        chk("rd_empty_count", 32'(count), 0);
        // Fill and overflow
        fill(8'h00, 16);
        chk("fill_count16", 32'(count), 16);
        chk("fill_no_ovf", 32'(ovf), 0);
        send(8'h10);
        chk("fill_ovf", 32'(ovf), 1);
        chk("fill_count_held", 32'(count), 16);
        drain(16);
        chk("fill_drained", 32'(count), 0);
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        // Simultaneous push and pop while full
        fill(8'h20, 16);
        inData = 8'hAA; inRdy = 1'b1; rd = 1'b1;
        exp_q.push_back(8'hAA);
        step();
        rd = 1'b0;
        chk("full_sim_inDone", 32'(inDone), 1);
        chk("full_sim_count", 32'(count), 16);
        chk("full_sim_ovf", 32'(ovf), 0);
        step();
        inRdy = 1'b0;
        drain(16);
        chk("full_sim_drained", 32'(count), 0);
        // Wrap with a shallow backlog
        fill(8'd1, 2);
        for (int v = 3; v <= 40; v++) begin
            exp_q.push_back(8'(v));
            send(8'(v));
            chk("wrap_count_push", 32'(count), 3);
            drain(1);
            chk("wrap_count_pop", 32'(count), 2);
        end
        drain(2);
        chk("wrap_drained", 32'(count), 0);
        // Stuck inRdy: one capture per two cycles
        inData = 8'h55; inRdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k % 2 == 1) exp_q.push_back(8'h55);
            step();
            chk("stuck_inDone", 32'(inDone), 32'(k % 2));
        end
        inRdy = 1'b0;
        chk("stuck_count", 32'(count), 5);
        // Reset mid-operation: overflow set, count 5, FSM in ACK
        fill(8'h60, 11);
        send(8'h70);
        chk("mid_ovf_set", 32'(ovf), 1);
        drain(12);
        inData = 8'h77; inRdy = 1'b1;
        step();
        chk("mid_count5", 32'(count), 5);
        chk("mid_in_ack", 32'(inDone), 1);
        rst = 1'b1;
        step();
        rst = 1'b0; inRdy = 1'b0;
        exp_q.delete();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_rdy", 32'(rdy), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_inDone", 32'(inDone), 0);
        step();
        chk("mid_no_late_ack", 32'(inDone), 0);
        chk("mid_stays_empty", 32'(count), 0);
        // Overflow coinciding with clrOvf: set wins
        fill(8'h80, 16);
        inData = 8'hEE; inRdy = 1'b1; clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        chk("set_wins_ovf", 32'(ovf), 1);
        chk("set_wins_count", 32'(count), 16);
        step();
        inRdy = 1'b0;
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        chk("clr_after_set", 32'(ovf), 0);
        drain(16);
        chk("final_count", 32'(count), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of byte entries; SHALL be a power of two, 4..64.
REQ-002 Parameter: AW, log2(DEPTH), pointer width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 inData  in  8  received byte from the serial receiver, valid while inRdy=1.
REQ-006 inRdy  in  1  receiver holds a byte; stays high until acknowledged.
REQ-007 inDone  out  1  one-cycle acknowledge to the receiver; the receiver clears inRdy on the following edge.
REQ-008 rd  in  1  bus read strobe for the data register; pops one byte.
REQ-009 data  out  8  head of FIFO, first-word fall-through; 0 when empty.
REQ-010 rdy  out  1  FIFO non-empty.
REQ-011 count  out  AW+1  current occupancy, 0..DEPTH.
REQ-012 ovf  out  1  sticky overflow flag.
REQ-013 clrOvf  in  1  clears ovf.

Function
REQ-014 Ingress FSM states: IDLE and ACK.
- IDLE with inRdy=1: write or drop, assert inDone for one cycle, go to ACK.
- ACK: ignore inRdy for that cycle, then return to IDLE.
- This limits ingress to one byte per 2 cycles and prevents a double-capture while the receiver clears inRdy.
REQ-015 Push: in IDLE with inRdy=1 and (count<DEPTH or pop this cycle), inData SHALL be written at wptr and wptr SHALL increment modulo DEPTH.
REQ-016 Full drop: in IDLE with inRdy=1, count=DEPTH and no pop, the byte SHALL be discarded, inDone SHALL still pulse, and ovf SHALL be set.
REQ-017 Pop: rd=1 and count>0 SHALL advance rptr modulo DEPTH; rd with count=0 SHALL have no effect.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and SHALL not set ovf, including when count=DEPTH.
REQ-019 count SHALL be +1 on push only and -1 on pop only; it SHALL never exceed DEPTH or go below 0.
REQ-020 data SHALL reflect the new head combinationally from registered pointers on the cycle after a pop.
- Latency: inRdy rising in IDLE to rdy=1 (from empty) is 1 cycle.
REQ-021 rdy SHALL equal (count!=0).
REQ-022 clrOvf SHALL clear ovf; if clrOvf coincides with a new overflow event, ovf SHALL end set (set wins).
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.

Reset
REQ-024 rst=1 SHALL on the next edge force: FSM=IDLE, wptr=rptr=0, count=0, ovf=0, inDone=0.
REQ-025 With rst=1: rdy=0, data=0; storage contents need not be cleared.
REQ-026 Reset asserted in ACK SHALL abandon the acknowledge with no second inDone pulse. A byte written in the same cycle is lost.
REQ-027 No push or pop SHALL take effect in any cycle where rst=1.

Structure
REQ-028 A shared package SHALL hold DEPTH default, AW, and the FSM state encoding (IDLE=0, ACK=1).
REQ-029 Storage SHALL be one sub-module, fifo_mem: DEPTH x 8, one synchronous write port and one asynchronous read port addressed by rptr.
- Pointer, count, FSM and ovf logic stay in uart_rx_fifo.
REQ-030 The I/O address decode that generates rd stays in the top level; this block SHALL not decode addresses.

Verification
REQ-031 Basic: after reset, inRdy=1 with inData=8'h41, receiver model dropping inRdy after inDone -> exactly one inDone pulse, rdy=1 and data=8'h41 one cycle later, count=1; rd -> rdy=0, data=0.
REQ-032 Fill: push 17 bytes 8'h00..8'h10 with no reads -> count=16 after the 16th; 17th gets inDone, ovf=1, count stays 16; 16 pops return 8'h00..8'h0F in order.
REQ-033 Full simultaneous: count=16, push 8'hAA with rd=1 in the same cycle -> count=16, ovf=0, after 16 pops last byte is 8'hAA.
REQ-034 Wrap: 40 push/pop pairs with values 1..40, never more than 3 queued -> output sequence 1..40 and correct count throughout.
REQ-035 Stuck inRdy: hold inRdy=1 for 10 cycles with inData=8'h55 -> inDone pulses on cycles 0,2,4,6,8 and count=5, confirming the 2-cycle ingress limit.
REQ-036 Reset mid-op: count=5, ovf=1, FSM in ACK, assert rst one cycle -> next cycle count=0, rdy=0, ovf=0, inDone=0; clrOvf coinciding with an overflow leaves ovf=1.
